// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory stream loader: FSM encoding and
// byte-lane sizing used by the top and the byte packer.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words; the finished word
// is registered and shown for exactly one cycle with word_valid_o.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic [LANE_W-1:0] lane_o,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    // Holds the lower three bytes; the fourth goes straight into word_o.
    logic [DATA_W-9:0] asm_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lane_o       <= '0;
            asm_q        <= '0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
        end else if (clear_i) begin
            lane_o       <= '0;
            asm_q        <= '0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
        end else begin
            word_valid_o <= 1'b0;
            if (byte_en_i) begin
                lane_o <= lane_o + 1'b1;
                if (lane_o == LANE_W'(BYTES_PER_WORD - 1)) begin
                    word_o       <= {byte_i, asm_q};
                    word_valid_o <= 1'b1;
                end else begin
                    asm_q[{lane_o, 3'b000} +: 8] <= byte_i;
                end
            end
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a count byte plus packed instruction words into instruction memory while
// holding the CPU in reset. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_stream_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              cpu_rst_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output state_t            dbg_state_o
);

    // Wide enough for 2^ADDR_W and for any raw count byte.
    localparam int CNT_W = (ADDR_W >= 8) ? ADDR_W + 1 : 9;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  words_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  count_ext;
    logic              rdy;
    logic              accept;
    logic              last_in;
    logic [LANE_W-1:0] pk_lane;
    logic              pk_valid;
    logic [DATA_W-1:0] pk_word;

    assign count_ext = {{(CNT_W-8){1'b0}}, byte_i};
    assign last_in   = (words_q == total_q);
    assign accept    = byte_valid_i && byte_ready_o;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
`endif

    // After the final word's last byte the load takes no more data bytes.
    always_comb begin
        rdy = 1'b0;
        case (state_q)
            ST_COUNT, ST_CHECK: rdy = 1'b1;
            ST_DATA:            rdy = !last_in;
            default:            rdy = 1'b0;
        endcase
        byte_ready_o = rdy && !load_req_i;
    end

    always_comb begin
        state_d = state_q;
        if (load_req_i) begin
            state_d = ST_COUNT;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (accept) state_d = (count_ext > DEPTH) ? ST_ERR : ST_DATA;
                end
                ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (pk_valid && last_in) state_d = ST_CHECK;
`else
                    if (pk_valid && last_in) state_d = ST_DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) state_d = (byte_i == chk_q) ? ST_DONE : ST_ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            total_q <= '0;
            words_q <= '0;
            addr_q  <= '0;
        end else if (load_req_i) begin
            total_q <= '0;
            words_q <= '0;
            addr_q  <= '0;
        end else begin
            if (state_q == ST_COUNT && accept)
                total_q <= (count_ext == '0) ? DEPTH : count_ext;
            if (state_q == ST_DATA && accept && pk_lane == LANE_W'(BYTES_PER_WORD - 1))
                words_q <= words_q + 1'b1;
            if (pk_valid)
                addr_q <= addr_q + 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            chk_q <= '0;
        else if (load_req_i)
            chk_q <= '0;
        else if (accept && (state_q == ST_COUNT || state_q == ST_DATA))
            chk_q <= chk_q ^ byte_i;
    end
`endif

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (load_req_i),
        .byte_en_i    (accept && state_q == ST_DATA),
        .byte_i       (byte_i),
        .lane_o       (pk_lane),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    assign imem_we_o   = pk_valid;
    assign imem_addr_o = addr_q;
    assign imem_data_o = pk_word;
    assign busy_o      = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign done_o      = (state_q == ST_DONE);
    assign cpu_rst_o   = (state_q == ST_DONE);
    assign start_o     = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERR);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: expected writes are queued as bytes are
// driven and popped by a write monitor; IMEM_LOADER_CHECKSUM_EN adds checksum cases.
module tb_imem_stream_loader;
    import loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              load_req_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_o;
    logic              cpu_rst_o;
    logic              start_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    state_t            dbg_state;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] mon_e;
    logic [7:0]               tb_chk;
    logic [46:0]              all_outs;
    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int wr_base;

    assign all_outs = {byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
                       cpu_rst_o, start_o, busy_o, done_o, err_o};

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    imem_stream_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_req_i   (load_req_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .start_o      (start_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic pulse_load();
        load_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        load_req_i = 1'b0;
        tb_chk = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  guard;
        logic ok;
        repeat ($urandom_range(0, gap)) begin
            @(posedge clk_i);
            #1;
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
        guard        = 0;
        ok           = 1'b0;
        while (!ok && guard < 100) begin
            @(negedge clk_i);
            ok = byte_ready_o;
            @(posedge clk_i);
            #1;
            guard++;
        end
        byte_valid_i = 1'b0;
        if (!ok) check("ready_timeout", 64'(ok), 64'(1));
        else     tb_chk = tb_chk ^ b;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a, input int gap);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = tb_chk;
        send_byte(c, 0);
`endif
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(done_o || err_o) && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check("end_timeout", 64'(done_o || err_o), 64'(1));
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (rst_i && imem_we_o) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("spurious_write", 64'(imem_we_o), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr_o), 64'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
                check("wr_data", 64'(imem_data_o), 64'(mon_e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        rst_i        = 1'b0;
        load_req_i   = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        tb_chk       = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outs", 64'(all_outs), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_ready", 64'(byte_ready_o), 64'(0));

        // basic two-word load with exact completion timing
        pulse_load();
        check("basic_busy", 64'(busy_o), 64'(1));
        send_byte(8'h02, 0);
        send_word(32'h00500513, 8'd0, 0);
        send_word(32'h00A58633, 8'd1, 0);
        @(negedge clk_i);
        check("basic_last_we", 64'({imem_we_o, imem_addr_o, done_o}), 64'({1'b1, 8'd1, 1'b0}));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_checksum();
        wait_end(20);
`else
        @(negedge clk_i);
`endif
        check("basic_done", 64'({done_o, start_o, cpu_rst_o, busy_o}), 64'(4'b1110));

        // gapped stream
        wr_base = n_wr;
        pulse_load();
        check("restart_drop", 64'({done_o, start_o, cpu_rst_o, err_o}), 64'(0));
        send_byte(8'h02, 3);
        send_word(32'h00500513, 8'd0, 3);
        send_word(32'h00A58633, 8'd1, 3);
        send_checksum();
        wait_end(50);
        repeat (3) @(negedge clk_i);
        check("gap_writes", 64'(n_wr - wr_base), 64'(2));
        check("gap_done", 64'(done_o), 64'(1));

        // full depth, count byte 0
        wr_base = n_wr;
        pulse_load();
        send_byte(8'h00, 0);
        for (int k = 0; k < 256; k++) send_word(32'(k), ADDR_W'(k), 0);
        send_checksum();
        wait_end(20);
        check("full_writes", 64'(n_wr - wr_base), 64'(256));
        check("full_done", 64'({done_o, start_o, cpu_rst_o}), 64'(3'b111));
        check("full_addr_wrap", 64'(imem_addr_o), 64'(0));

        // abort mid-load, then a fresh one-word load
        pulse_load();
        check("abort_drop", 64'({done_o, start_o, cpu_rst_o, busy_o}), 64'(4'b0001));
        send_byte(8'h02, 0);
        send_word(32'h11223344, 8'd0, 0);
        send_byte(8'hAA, 0);
        check("abort_hold1", 64'({cpu_rst_o, start_o}), 64'(0));
        pulse_load();
        check("abort_hold2", 64'({cpu_rst_o, start_o, busy_o}), 64'(3'b001));
        send_byte(8'h01, 0);
        send_word(32'h0000006F, 8'd0, 0);
        check("abort_hold3", 64'({cpu_rst_o, start_o}), 64'(0));
        send_checksum();
        wait_end(20);
        check("abort_done", 64'({done_o, cpu_rst_o, start_o}), 64'(3'b111));

        // asynchronous reset in the middle of DATA
        pulse_load();
        send_byte(8'h02, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        #3;
        check("pre_reset_busy", 64'(busy_o), 64'(1));
        rst_i = 1'b0;
        #1;
        check("async_reset_outs", 64'(all_outs), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_reset_state", 64'(dbg_state), 64'(ST_IDLE));
        check("post_reset_ready", 64'(byte_ready_o), 64'(0));
        @(posedge clk_i);
        #1;

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_load();
        send_byte(8'h01, 0);
        send_word(32'h00000013, 8'd0, 0);
        send_byte(8'h12, 0);
        wait_end(20);
        check("chk_good", 64'({done_o, err_o, start_o}), 64'(3'b101));

        pulse_load();
        send_byte(8'h01, 0);
        send_word(32'h00000013, 8'd0, 0);
        send_byte(8'h00, 0);
        wait_end(20);
        check("chk_bad", 64'({err_o, done_o, start_o, cpu_rst_o}), 64'(4'b1000));
`endif

        repeat (5) @(negedge clk_i);
        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
